aes_job_ctrl: RTL and testbench

Job scheduler sharing one AES encrypt core (`aes_cipher_top`) and one AES decrypt core (`aes_inv_cipher_top`) among a stream of requests. It accepts encrypt or decrypt jobs over a valid/ready interface and sequences each core's `ld`/`kld` strobes. For decryption it caches the expanded key, so a repeated key skips the key-expansion pass. It returns results, with a timeout error flag, on a valid/ready response port; it sits between the system bus adapter and the two cores.

---
 rtl/aes_ctrl_pkg.sv | 17 +
 rtl/aes_key_cache.sv | 38 +++
 rtl/aes_job_ctrl.sv | 177 +++++++++++++++++
 tb/tb_aes_job_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES job controller.
// Contents: FSM state encoding, request mode constants and the AES block width.
package aes_ctrl_pkg;

    localparam int AES_BLK_W = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEXP = 2'd1,
        ST_LOAD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

endpackage

// File: rtl/aes_key_cache.sv
// Cache of the key most recently expanded by the decrypt core.
// Ports:
//   clk, rst     clock and asynchronous active-low reset
//   i_key        key to compare against the cached key
//   i_upd        load i_upd_key as the cached key and mark it valid
//   i_upd_key    key captured on update
//   i_inv        invalidate the cache (takes priority over i_upd)
//   o_hit        cache is valid and i_key matches the cached key
module aes_key_cache
    import aes_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AES_BLK_W-1:0] i_key,
    input  logic                 i_upd,
    input  logic [AES_BLK_W-1:0] i_upd_key,
    input  logic                 i_inv,
    output logic                 o_hit
);

    logic [AES_BLK_W-1:0] r_cached_key;
    logic                 r_key_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cached_key <= '0;
            r_key_valid  <= 1'b0;
        end else if (i_inv) begin
            r_key_valid  <= 1'b0;
        end else if (i_upd) begin
            r_cached_key <= i_upd_key;
            r_key_valid  <= 1'b1;
        end
    end

    assign o_hit = r_key_valid && (i_key == r_cached_key);

endmodule

// File: rtl/aes_job_ctrl.sv
// Job scheduler in front of one AES encrypt core and one AES decrypt core.
// Ports:
//   clk, rst                     clock and asynchronous active-low reset
//   req_*                        job request (valid/ready, mode, key, data, tag)
//   rsp_*                        single-entry result (valid/ready, data, tag, timeout error)
//   enc_ld/enc_key/enc_text_in   encrypt-core controls; enc_text_out/enc_done its result
//   dec_ld/dec_kld/dec_key/...   decrypt-core controls; dec_text_out/dec_done/dec_kdone its result
//   busy                         controller is working on a job
// The decrypt key schedule is cached, so a repeated decrypt key skips the kld pass.
module aes_job_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_mode,
    input  logic [AES_BLK_W-1:0] req_key,
    input  logic [AES_BLK_W-1:0] req_data,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [AES_BLK_W-1:0] rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_err,
    output logic                 enc_ld,
    output logic [AES_BLK_W-1:0] enc_key,
    output logic [AES_BLK_W-1:0] enc_text_in,
    input  logic [AES_BLK_W-1:0] enc_text_out,
    input  logic                 enc_done,
    output logic                 dec_ld,
    output logic                 dec_kld,
    output logic [AES_BLK_W-1:0] dec_key,
    output logic [AES_BLK_W-1:0] dec_text_in,
    input  logic [AES_BLK_W-1:0] dec_text_out,
    input  logic                 dec_done,
    input  logic                 dec_kdone,
    output logic                 busy
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    state_t               r_state, w_state_next;
    logic                 r_job_mode;
    logic [AES_BLK_W-1:0] r_job_key, r_job_data;
    logic [TAG_W-1:0]     r_job_tag;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_rsp_valid, r_rsp_err;
    logic [AES_BLK_W-1:0] r_rsp_data;
    logic [TAG_W-1:0]     r_rsp_tag;

    logic w_accept, w_hit, w_expired, w_kdone_ok, w_done_ok, w_timeout;

    assign req_ready = (r_state == ST_IDLE) && (!r_rsp_valid || rsp_ready);
    assign w_accept  = req_valid && req_ready;
    assign w_expired = (r_timer == TMR_MAX);
    assign busy      = (r_state != ST_IDLE);

    // Both cores see the job registers; they hold steady until the next accept.
    assign enc_key     = r_job_key;
    assign enc_text_in = r_job_data;
    assign dec_key     = r_job_key;
    assign dec_text_in = r_job_data;

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_err   = r_rsp_err;

    aes_key_cache u_key_cache (
        .clk       (clk),
        .rst       (rst),
        .i_key     (req_key),
        .i_upd     (w_kdone_ok),
        .i_upd_key (r_job_key),
        .i_inv     (w_timeout),
        .o_hit     (w_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_kdone_ok   = 1'b0;
        w_done_ok    = 1'b0;
        w_timeout    = 1'b0;
        enc_ld       = 1'b0;
        dec_ld       = 1'b0;
        dec_kld      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_next = (req_mode == MODE_DEC && !w_hit) ? ST_KEXP : ST_LOAD;
            end
            ST_KEXP: begin
                // Timer is cleared on entry, so zero marks the first KEXP cycle.
                dec_kld = (r_timer == '0);
                if (dec_kdone) begin
                    w_kdone_ok   = 1'b1;
                    w_state_next = ST_LOAD;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                enc_ld       = (r_job_mode == MODE_ENC);
                dec_ld       = (r_job_mode == MODE_DEC);
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if ((r_job_mode == MODE_DEC) ? dec_done : enc_done) begin
                    w_done_ok    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_job_mode <= MODE_ENC;
            r_job_key  <= '0;
            r_job_data <= '0;
            r_job_tag  <= '0;
        end else if (w_accept) begin
            r_job_mode <= req_mode;
            r_job_key  <= req_key;
            r_job_data <= req_data;
            r_job_tag  <= req_tag;
        end
    end

    // Saturating wait counter; cleared outside the two waiting states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_timer <= '0;
        else if (r_state == ST_KEXP || r_state == ST_RUN) begin
            if (!w_expired) r_timer <= r_timer + TMR_W'(1);
        end else
            r_timer <= '0;
    end

    // One-entry response register; a new result beats the pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
        end else if (w_done_ok) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= (r_job_mode == MODE_DEC) ? dec_text_out : enc_text_out;
            r_rsp_tag   <= r_job_tag;
        end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_tag   <= r_job_tag;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_job_ctrl.sv
module tb_aes_job_ctrl;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KF = {128{1'b1}};
    localparam logic [127:0] XF = 128'hffeeddccbbaa99887766554433221100;
    localparam int ENC_LAT  = 5;
    localparam int DEC_LAT  = 6;
    localparam int KEXP_LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0, req_mode = 1'b0;
    logic         req_ready;
    logic [127:0] req_key = '0, req_data = '0;
    logic [3:0]   req_tag = '0;
    logic         rsp_valid, rsp_err;
    logic         rsp_ready = 1'b1;
    logic [127:0] rsp_data;
    logic [3:0]   rsp_tag;
    logic         enc_ld, dec_ld, dec_kld, busy;
    logic [127:0] enc_key, enc_text_in, dec_key, dec_text_in;
    logic [127:0] enc_text_out, dec_text_out;
    logic         enc_done, dec_done, dec_kdone;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int kld_cnt = 0;
    int ld_cnt = 0;
    logic stub_hang = 1'b0;

    always #5 clk = ~clk;

    aes_job_ctrl #(.TAG_W(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_data(req_data), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .enc_ld(enc_ld), .enc_key(enc_key), .enc_text_in(enc_text_in),
        .enc_text_out(enc_text_out), .enc_done(enc_done),
        .dec_ld(dec_ld), .dec_kld(dec_kld), .dec_key(dec_key), .dec_text_in(dec_text_in),
        .dec_text_out(dec_text_out), .dec_done(dec_done), .dec_kdone(dec_kdone),
        .busy(busy)
    );

    // Stub cores: the FIPS-197 pair is known exactly; other inputs use data^key.
    function automatic logic [127:0] enc_f(input logic [127:0] k, input logic [127:0] d);
        if (k == K0 && d == P0) return C0;
        return d ^ k;
    endfunction

    function automatic logic [127:0] dec_f(input logic [127:0] k, input logic [127:0] d);
        if (k == K0 && d == C0) return P0;
        return d ^ k;
    endfunction

    int e_cnt = 0, d_cnt = 0, k_cnt = 0;
    logic [127:0] exp_key;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_cnt <= 0; enc_done <= 1'b0; enc_text_out <= '0;
        end else begin
            enc_done <= 1'b0;
            if (enc_ld) e_cnt <= ENC_LAT;
            else if (e_cnt > 0) begin
                e_cnt <= e_cnt - 1;
                if (e_cnt == 1 && !stub_hang) begin
                    enc_done     <= 1'b1;
                    enc_text_out <= enc_f(enc_key, enc_text_in);
                end
            end
        end
    end

    // Decrypt stub only knows the key it was told to expand via kld.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_cnt <= 0; k_cnt <= 0; exp_key <= '0;
            dec_done <= 1'b0; dec_kdone <= 1'b0; dec_text_out <= '0;
        end else begin
            dec_done  <= 1'b0;
            dec_kdone <= 1'b0;
            if (dec_kld) k_cnt <= KEXP_LAT;
            else if (k_cnt > 0) begin
                k_cnt <= k_cnt - 1;
                if (k_cnt == 1) begin
                    dec_kdone <= 1'b1;
                    exp_key   <= dec_key;
                end
            end
            if (dec_ld) d_cnt <= DEC_LAT;
            else if (d_cnt > 0) begin
                d_cnt <= d_cnt - 1;
                if (d_cnt == 1 && !stub_hang) begin
                    dec_done     <= 1'b1;
                    dec_text_out <= dec_f(exp_key, dec_text_in);
                end
            end
        end
    end

    // Strobe monitor: no strobe while idle, none longer than one cycle.
    logic p_e = 1'b0, p_d = 1'b0, p_k = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_e <= 1'b0; p_d <= 1'b0; p_k <= 1'b0;
        end else begin
            p_e <= enc_ld; p_d <= dec_ld; p_k <= dec_kld;
            if (((enc_ld || dec_ld || dec_kld) && !busy) ||
                (enc_ld && p_e) || (dec_ld && p_d) || (dec_kld && p_k))
                viol <= viol + 1;
            kld_cnt <= kld_cnt + int'(dec_kld);
            ld_cnt  <= ld_cnt + int'(enc_ld) + int'(dec_ld);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_job(input logic m, input logic [127:0] k, input logic [127:0] d,
                            input logic [3:0] t, output int waited);
        req_mode = m; req_key = k; req_data = d; req_tag = t; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL accept_wait tag=%h req_ready=%b exp 1", t, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [127:0] d, output logic [3:0] t,
                            output logic e, output int waited);
        waited = 0;
        while (!rsp_valid && waited < 500) begin
            @(posedge clk); #1; waited++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL rsp_wait rsp_valid=%b exp 1", rsp_valid);
        end
        d = rsp_data; t = rsp_tag; e = rsp_err;
        $display("rsp tag=%h data=%h err=%b cycles=%0d", t, d, e, waited);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, busy, rsp_valid, rsp_err, enc_ld, dec_ld, dec_kld} !== 7'b1000000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 1000000",
                {req_ready, busy, rsp_valid, rsp_err, enc_ld, dec_ld, dec_kld});
        end
        checks++;
        if ({rsp_data, rsp_tag} !== '0) begin
            errors++; $display("FAIL reset_rsp got %h/%h exp 0/0", rsp_data, rsp_tag);
        end
        checks++;
        if ({enc_key, enc_text_in, dec_key, dec_text_in} !== '0) begin
            errors++; $display("FAIL reset_buses got %h %h exp 0", enc_key, dec_text_in);
        end
        @(negedge clk); rst = 1'b1;
        step();
    endtask

    task automatic test_encrypt();
        logic [127:0] d; logic [3:0] t; logic e; int w, n, k0;
        k0 = kld_cnt;
        send_job(1'b0, K0, P0, 4'h3, w);
        checks++;
        if ({enc_ld, dec_ld, dec_kld, busy} !== 4'b1001) begin
            errors++; $display("FAIL enc_ld_cycle1 got %b exp 1001", {enc_ld, dec_ld, dec_kld, busy});
        end
        wait_rsp(d, t, e, n);
        checks++;
        if (d !== C0) begin errors++; $display("FAIL enc_data got %h exp %h", d, C0); end
        checks++;
        if ({t, e} !== {4'h3, 1'b0}) begin errors++; $display("FAIL enc_tag_err got %h/%b exp 3/0", t, e); end
        checks++;
        if (n !== ENC_LAT + 2) begin errors++; $display("FAIL enc_latency got %0d exp %0d", n, ENC_LAT + 2); end
        checks++;
        if (kld_cnt !== k0) begin errors++; $display("FAIL enc_no_kld got %0d exp %0d", kld_cnt, k0); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] d; logic [3:0] t; logic e; int w, n, k0;
        k0 = kld_cnt;
        send_job(1'b1, K0, C0, 4'h5, w);
        checks++;
        if ({dec_kld, dec_ld, enc_ld} !== 3'b100) begin
            errors++; $display("FAIL miss_kld_cycle1 got %b exp 100", {dec_kld, dec_ld, enc_ld});
        end
        wait_rsp(d, t, e, n);
        checks++;
        if ({d, t, e} !== {P0, 4'h5, 1'b0}) begin errors++; $display("FAIL miss_rsp got %h/%h/%b exp %h/5/0", d, t, e, P0); end
        checks++;
        if (n !== KEXP_LAT + DEC_LAT + 4) begin errors++; $display("FAIL miss_latency got %0d exp %0d", n, KEXP_LAT + DEC_LAT + 4); end
        send_job(1'b1, K0, C0, 4'h6, w);
        checks++;
        if (w !== 0) begin errors++; $display("FAIL b2b_accept waited %0d exp 0", w); end
        checks++;
        if ({dec_kld, dec_ld} !== 2'b01) begin errors++; $display("FAIL hit_ld_cycle1 got %b exp 01", {dec_kld, dec_ld}); end
        wait_rsp(d, t, e, n);
        checks++;
        if ({d, t, e} !== {P0, 4'h6, 1'b0}) begin errors++; $display("FAIL hit_rsp got %h/%h/%b exp %h/6/0", d, t, e, P0); end
        checks++;
        if (n !== DEC_LAT + 2) begin errors++; $display("FAIL hit_latency got %0d exp %0d", n, DEC_LAT + 2); end
        checks++;
        if (kld_cnt - k0 !== 1) begin errors++; $display("FAIL miss_hit_kld got %0d exp 1", kld_cnt - k0); end
        step();
    endtask

    task automatic test_key_change();
        logic [127:0] d; logic [3:0] t; logic e; int w, n, k0;
        k0 = kld_cnt;
        send_job(1'b1, K0, C0, 4'h7, w);
        wait_rsp(d, t, e, n);
        checks++;
        if (d !== P0) begin errors++; $display("FAIL kc_first got %h exp %h", d, P0); end
        step();
        send_job(1'b1, KF, P0, 4'h8, w);
        checks++;
        if (dec_kld !== 1'b1) begin errors++; $display("FAIL kc_kld got %b exp 1", dec_kld); end
        wait_rsp(d, t, e, n);
        checks++;
        if ({d, t} !== {XF, 4'h8}) begin errors++; $display("FAIL kc_second got %h/%h exp %h/8", d, t, XF); end
        checks++;
        if (kld_cnt - k0 !== 1) begin errors++; $display("FAIL kc_kld_count got %0d exp 1", kld_cnt - k0); end
        step();
    endtask

    task automatic test_backpressure();
        logic [127:0] d; logic [3:0] t; logic e; int w, n, l0, bad;
        rsp_ready = 1'b0;
        send_job(1'b0, K0, P0, 4'h9, w);
        wait_rsp(d, t, e, n);
        checks++;
        if (d !== C0) begin errors++; $display("FAIL bp_data got %h exp %h", d, C0); end
        req_mode = 1'b0; req_key = K0; req_data = P0; req_tag = 4'ha; req_valid = 1'b1;
        l0 = ld_cnt; bad = 0;
        repeat (20) begin
            step();
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== C0 || rsp_tag !== 4'h9) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d exp 0", bad); end
        checks++;
        if (ld_cnt !== l0) begin errors++; $display("FAIL bp_no_ld got %0d exp %0d", ld_cnt, l0); end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++;
        if ({enc_ld, rsp_valid} !== 2'b10) begin errors++; $display("FAIL bp_accept got %b exp 10", {enc_ld, rsp_valid}); end
        wait_rsp(d, t, e, n);
        checks++;
        if ({d, t} !== {C0, 4'ha}) begin errors++; $display("FAIL bp_next got %h/%h exp %h/a", d, t, C0); end
        step();
    endtask

    task automatic test_timeout();
        logic [127:0] d; logic [3:0] t; logic e; int w, n;
        stub_hang = 1'b1;
        send_job(1'b1, KF, P0, 4'hb, w);
        checks++;
        if ({dec_kld, dec_ld} !== 2'b01) begin errors++; $display("FAIL to_hit got %b exp 01", {dec_kld, dec_ld}); end
        wait_rsp(d, t, e, n);
        checks++;
        if (n !== 65) begin errors++; $display("FAIL to_latency got %0d exp 65", n); end
        checks++;
        if ({d, t, e} !== {128'h0, 4'hb, 1'b1}) begin errors++; $display("FAIL to_rsp got %h/%h/%b exp 0/b/1", d, t, e); end
        step();
        stub_hang = 1'b0;
        send_job(1'b1, KF, P0, 4'hc, w);
        checks++;
        if (dec_kld !== 1'b1) begin errors++; $display("FAIL to_rekld got %b exp 1", dec_kld); end
        wait_rsp(d, t, e, n);
        checks++;
        if ({d, e} !== {XF, 1'b0}) begin errors++; $display("FAIL to_after got %h/%b exp %h/0", d, e, XF); end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] d; logic [3:0] t; logic e; int w, n;
        stub_hang = 1'b1;
        send_job(1'b1, KF, P0, 4'hd, w);
        repeat (5) step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy got %b exp 1", busy); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, busy, rsp_valid, rsp_err, enc_ld, dec_ld, dec_kld} !== 7'b1000000) begin
            errors++; $display("FAIL rr_ctrl got %b exp 1000000",
                {req_ready, busy, rsp_valid, rsp_err, enc_ld, dec_ld, dec_kld});
        end
        checks++;
        if ({dec_key, dec_text_in, rsp_data} !== '0) begin
            errors++; $display("FAIL rr_buses got %h/%h exp 0", dec_key, rsp_data);
        end
        @(negedge clk); rst = 1'b1; stub_hang = 1'b0;
        step();
        send_job(1'b1, KF, P0, 4'he, w);
        checks++;
        if (dec_kld !== 1'b1) begin errors++; $display("FAIL rr_rekld got %b exp 1", dec_kld); end
        wait_rsp(d, t, e, n);
        checks++;
        if ({d, t, e} !== {XF, 4'he, 1'b0}) begin errors++; $display("FAIL rr_rsp got %h/%h/%b exp %h/e/0", d, t, e, XF); end
        step();
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_back_to_back();
        test_key_change();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL strobe_rules violations=%0d exp 0", viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
